exe_issue: RTL and testbench

EXE_ISSUE -- requirements
Module: exe_issue

---
 rtl/exe_issue.sv | 100 ++++++++++
 tb/tb_exe_issue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue.sv
// exe_issue: request FIFO feeding a single-outstanding execution unit,
// with a WAIT timeout and a writeback slot held until accepted.
module exe_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_tag,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        exe_start,
  output logic [2:0]  exe_op,
  output logic [31:0] exe_a,
  output logic [31:0] exe_b,
  input  logic        exe_valid,
  input  logic [31:0] exe_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_tag,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t        r_state, w_next;
  logic [70:0]   r_mem [DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_tag;
  logic [2:0]    r_op;
  logic [31:0]   r_a, r_b, r_data;
  logic          r_err;
  logic [70:0]   w_head;
  logic          w_empty, w_full, w_push, w_pop, w_legal, w_last;
  assign w_head  = r_mem[r_rp[AW-1:0]];
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = req_valid && !w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_legal = w_head[66:64] < 3'd2;
  assign w_last  = r_cnt == LAST;
  assign req_ready = !w_full;
  assign exe_start = r_state == ISSUE;
  assign exe_op    = r_op;
  assign exe_a     = r_a;
  assign exe_b     = r_b;
  assign wb_valid  = r_state == HOLD;
  assign wb_tag    = r_tag;
  assign wb_data   = r_data;
  assign wb_err    = r_err;
  assign busy      = (r_state != IDLE) || !w_empty;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_empty ? IDLE : (w_legal ? ISSUE : HOLD);
      ISSUE: w_next = WAIT;
      WAIT:  w_next = (exe_valid || w_last) ? HOLD : WAIT;
      HOLD:  w_next = wb_ready ? IDLE : HOLD;
    endcase
  end
  // Storage needs no reset: the pointers alone define occupancy.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {req_tag, req_op, req_a, req_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wp    <= r_wp + (AW+1)'(w_push);
      r_rp    <= r_rp + (AW+1)'(w_pop);
      if (w_pop) begin
        {r_tag, r_op, r_a, r_b} <= w_head;
        r_err  <= !w_legal;
        r_data <= '0;
      end
      if (r_state == ISSUE) r_cnt <= '0;
      if (r_state == WAIT) begin
        r_cnt  <= r_cnt + CW'(1);
        r_data <= exe_valid ? exe_result : '0;
        r_err  <= !exe_valid;
      end
    end
  end
endmodule

// File: tb/tb_exe_issue.sv
// tb_exe_issue: scoreboard bench with a latency-programmable execution-unit model.
module tb_exe_issue;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic [3:0]  req_tag = 0;
  logic [2:0]  req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic        exe_start, exe_valid = 0;
  logic [2:0]  exe_op;
  logic [31:0] exe_a, exe_b, exe_result = 0;
  logic        wb_valid, wb_ready = 0, wb_err, busy;
  logic [3:0]  wb_tag;
  logic [31:0] wb_data;

  exe_issue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .exe_start(exe_start), .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b),
    .exe_valid(exe_valid), .exe_result(exe_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {logic [3:0] tag; logic [31:0] data; logic err; int nstart; int dly;} exp_t;
  exp_t sb[$];
  int   lq[$];
  int   checks = 0, errors = 0;
  int   n_legal = 0, n_starts = 0, n_wb = 0, last_start = 0, cyc = 0;
  int   wbr_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected writeback from the request alone: add gives a+b, sub gives b-a,
  // other ops error out; a unit that answers after 16 WAIT cycles is a timeout.
  task automatic push_exp(input logic [3:0] tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
    exp_t e;
    bit ok;
    e.tag = tag;
    if (op < 2) begin
      n_legal++;
      lq.push_back(lat);
      ok = lat >= 1 && lat <= 16;
      e.data = ok ? (op == 0 ? a + b : b - a) : 32'd0;
      e.err = !ok;
      e.dly = ok ? lat + 1 : 17;
    end else begin
      e.data = 0;
      e.err = 1;
      e.dly = -1;
    end
    e.nstart = n_legal;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input int lat);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_tag = tag; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    if (req_ready) push_exp(tag, op, a, b, lat);
    else chk("req_accept_timeout", 0, 1);
  endtask

  task automatic stop_req();
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_timeout", {31'd0, busy || sb.size() != 0}, 0);
  endtask

  initial forever begin
    @(negedge clk);
    wb_ready = (wbr_mode == 2) ? 1'($urandom % 2) : (wbr_mode == 1);
  end

  // Execution-unit model: answers L cycles after the start cycle; L=0 never answers.
  // While idle it throws stray exe_valid pulses that the DUT must ignore.
  initial begin
    int l;
    logic [31:0] res;
    forever begin
      @(negedge clk);
      exe_valid = 0;
      if (rst) continue;
      if (exe_start) begin
        n_starts++;
        last_start = cyc;
        chk("exe_op_legal", {31'd0, exe_op < 3'd2}, 1);
        if (lq.size() == 0) begin chk("spurious_start", 1, 0); l = 1; end
        else l = lq.pop_front();
        res = (exe_op == 3'd1) ? exe_b - exe_a : exe_a + exe_b;
        if (l == 0) repeat (17) @(negedge clk);
        else begin
          repeat (l) @(negedge clk);
          exe_valid = 1;
          exe_result = res;
        end
      end else if ($urandom % 6 == 0) begin
        exe_valid = 1;
        exe_result = $urandom;
      end
    end
  end

  initial begin
    bit pv = 0, ps = 0;
    exp_t e;
    logic [3:0] h_tag;
    logic [31:0] h_data;
    logic h_err;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin pv = 0; ps = 0; continue; end
      if (exe_start) chk("start_width", {31'd0, ps}, 0);
      ps = exe_start;
      if (wb_valid) begin
        if (!pv) begin
          n_wb++;
          if (sb.size() == 0) chk("wb_unexpected", {28'd0, wb_tag}, 32'hFFFF);
          else begin
            e = sb[0];
            chk("wb_tag", {28'd0, wb_tag}, {28'd0, e.tag});
            chk("wb_data", wb_data, e.data);
            chk("wb_err", {31'd0, wb_err}, {31'd0, e.err});
            chk("start_count", n_starts, e.nstart);
            if (e.dly >= 0) chk("latency", cyc - last_start, e.dly);
          end
          h_tag = wb_tag; h_data = wb_data; h_err = wb_err;
        end else begin
          chk("hold_tag", {28'd0, wb_tag}, {28'd0, h_tag});
          chk("hold_data", wb_data, h_data);
          chk("hold_err", {31'd0, wb_err}, {31'd0, h_err});
        end
        if (wb_ready && sb.size() != 0) void'(sb.pop_front());
      end
      pv = wb_valid && !wb_ready;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, w0, n;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_exe_start", {31'd0, exe_start}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_err", {31'd0, wb_err}, 0);
    chk("rst_wb_tag", {28'd0, wb_tag}, 0);
    @(negedge clk);
    rst = 0;

    send(3, 0, 5, 7, 2);
    stop_req();
    wait_idle();
    chk("one_start", n_starts, 1);

    send(5, 1, 1, 0, 3);
    stop_req();
    wait_idle();

    wbr_mode = 0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      req_valid = 1; req_tag = 4'(acc + 4); req_op = 0;
      req_a = 32'(acc * 3); req_b = 100;
      if (req_ready) begin push_exp(req_tag, 0, req_a, req_b, 1); acc++; end
    end
    #1;
    chk("fill_count", acc, 5);
    chk("full_ready", {31'd0, req_ready}, 0);
    stop_req();
    wbr_mode = 1;
    wait_idle();

    n0 = n_starts;
    send(9, 5, 32'h1234, 32'h5678, 0);
    stop_req();
    wait_idle();
    chk("illegal_no_start", n_starts, n0);

    send(1, 0, 10, 20, 0);
    send(2, 1, 3, 10, 4);
    stop_req();
    wait_idle();

    n0 = n_starts;
    send(4, 0, 1, 2, 10);
    stop_req();
    n = 0;
    while (n_starts == n0 && n < 50) begin @(negedge clk); n++; end
    chk("rst_test_started", {31'd0, n_starts != n0}, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_wb_valid", {31'd0, wb_valid}, 0);
    chk("async_req_ready", {31'd0, req_ready}, 1);
    chk("async_exe_start", {31'd0, exe_start}, 0);
    sb.delete(); lq.delete(); n_legal = 0; n_starts = 0;
    @(negedge clk);
    rst = 0;
    w0 = n_wb;
    repeat (30) @(negedge clk);
    chk("no_wb_after_rst", n_wb, w0);
    chk("idle_after_rst", {31'd0, busy}, 0);

    wbr_mode = 2;
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      int lat, r;
      op = ($urandom % 8 < 6) ? 3'($urandom % 2) : 3'(2 + $urandom % 6);
      r = $urandom % 10;
      lat = (r == 0) ? 0 : (r == 1) ? 17 + $urandom % 2 : 1 + $urandom % 16;
      send(4'($urandom), op, $urandom, $urandom, lat);
      if ($urandom % 4 == 0) stop_req();
    end
    stop_req();
    wbr_mode = 1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
